// File: rtl/xor_bind_pkg.sv
// xor_bind_pkg
// Shared types and constants for the XOR equivalence checker.
//   chk_state_e : checker FSM states (IDLE, RUN, HALT)
//   LATENCY_MAX : deepest supported compare pipeline
//   params_ok() : elaboration-time legality check of the parameter set
package xor_bind_pkg;

  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } chk_state_e;

  function automatic bit params_ok(input int width, input int latency, input int cnt_w);
    return (width >= 1) && (latency >= 0) && (latency <= LATENCY_MAX) && (cnt_w >= 2);
  endfunction

endpackage

// File: rtl/xor_bind_delay.sv
// xor_bind_delay
// {valid, data} shift line of LATENCY stages. Reset clears only the valid
// bits, which is enough to flush every beat in flight. LATENCY=0 is a
// combinational pass-through.
//   clk       : rising-edge clock
//   rst       : synchronous, active-high clear of the valid bits
//   in_valid  : beat launched this cycle
//   in_data   : payload of the launched beat
//   out_valid : beat leaving the line this cycle
//   out_data  : payload of the leaving beat
module xor_bind_delay #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (LATENCY == 0) begin : g_pass
    assign out_valid = in_valid;
    assign out_data  = in_data;

    // No storage in this configuration; clock and reset are intentionally idle.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
  end else begin : g_line
    logic [LATENCY-1:0] valid_q;
    logic [WIDTH-1:0]   data_q [LATENCY];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its neighbour held before this edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= in_valid;
        for (int i = 1; i < LATENCY; i++) begin
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    // NOTE: the payload array has no reset; it is qualified by valid_q, so
    // resetting it would only add reset fan-out for no behavioural gain.
    always_ff @(posedge clk) begin
      data_q[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];
  end

endmodule

// File: rtl/xor_bind_checker.sv
// xor_bind_checker
// Observation-only monitor, attached with `bind <target> xor_bind_checker
// chk_i (.*);`. Checks that c equals a^b launched LATENCY cycles earlier,
// counts compares and mismatches, captures the first failing difference and
// can stop checking after the first failure.
//   clk, rst   : clock and synchronous active-high reset
//   en         : launch qualifier for the operand sample
//   clr        : synchronous clear of counters/sticky state (pipeline kept)
//   a, b, c    : operands and observed result
//   mismatch   : one-cycle pulse per failing compare
//   err        : sticky first-failure flag
//   err_count  : saturating mismatch count
//   first_diff : expected ^ c of the first mismatch
//   checked    : saturating count of completed compares
//   halted     : checker stopped after a failure
module xor_bind_checker
  import xor_bind_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int LATENCY      = 1,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             mismatch,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] first_diff,
  output logic [CNT_W-1:0] checked,
  output logic             halted
);

  if (!params_ok(WIDTH, LATENCY, CNT_W)) begin : g_param_err
    $error("xor_bind_checker: illegal WIDTH/LATENCY/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  chk_state_e       state_q, state_d;
  logic             launch;
  logic             cmp_valid;
  logic [WIDTH-1:0] cmp_exp;
  logic             fire;
  logic             miss;
  logic [WIDTH-1:0] diff;

  // HALT blocks new launches; IDLE launches so the first en beat is not lost.
  assign launch = en && (state_q != HALT);

  xor_bind_delay #(
    .LATENCY (LATENCY),
    .WIDTH   (WIDTH)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (launch),
    .in_data   (a ^ b),
    .out_valid (cmp_valid),
    .out_data  (cmp_exp)
  );

  // Beats reaching the compare point in HALT, or in a clr cycle, are dropped.
  assign fire = cmp_valid && (state_q != HALT) && !clr;
  assign diff = cmp_exp ^ c;
  assign miss = fire && (diff != '0);

  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (STOP_ON_FAIL && miss) state_d = HALT;
        else if (en)              state_d = RUN;
      end
      RUN: begin
        if (STOP_ON_FAIL && miss) state_d = HALT;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch   <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      first_diff <= '0;
      checked    <= '0;
      halted     <= 1'b0;
    end else begin
      mismatch <= miss;
      halted   <= (state_d == HALT);
      if (clr) begin
        err        <= 1'b0;
        err_count  <= '0;
        first_diff <= '0;
        checked    <= '0;
      end else begin
        if (fire && (checked != '1)) checked <= checked + CNT_ONE;
        if (miss) begin
          err <= 1'b1;
          if (err_count != '1) err_count <= err_count + CNT_ONE;
          if (!err)            first_diff <= diff;
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_bind_checker.sv
// tb_xor_bind_checker
// Four checker instances share one stimulus bus; each test resets all of
// them and observes the instance whose parameters it targets:
//   0: LATENCY=1            1: LATENCY=2
//   2: LATENCY=3, STOP=1    3: LATENCY=1, CNT_W=2
// Expected mismatch pulses are queued when a beat is driven and popped on
// the cycle the flag must appear.
module tb_xor_bind_checker;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [7:0] a, b, c;

  logic        mis_o  [4];
  logic        err_o  [4];
  logic        halt_o [4];
  logic [7:0]  fd_o   [4];
  logic [15:0] ecnt_w [3];
  logic [15:0] chk_w  [3];
  logic [1:0]  ec3, ck3;

  always #5 clk = ~clk;

  xor_bind_checker #(.WIDTH(8), .LATENCY(1), .CNT_W(16), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .mismatch(mis_o[0]), .err(err_o[0]), .err_count(ecnt_w[0]),
    .first_diff(fd_o[0]), .checked(chk_w[0]), .halted(halt_o[0]));

  xor_bind_checker #(.WIDTH(8), .LATENCY(2), .CNT_W(16), .STOP_ON_FAIL(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .mismatch(mis_o[1]), .err(err_o[1]), .err_count(ecnt_w[1]),
    .first_diff(fd_o[1]), .checked(chk_w[1]), .halted(halt_o[1]));

  xor_bind_checker #(.WIDTH(8), .LATENCY(3), .CNT_W(16), .STOP_ON_FAIL(1'b1)) u2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .mismatch(mis_o[2]), .err(err_o[2]), .err_count(ecnt_w[2]),
    .first_diff(fd_o[2]), .checked(chk_w[2]), .halted(halt_o[2]));

  xor_bind_checker #(.WIDTH(8), .LATENCY(1), .CNT_W(2), .STOP_ON_FAIL(1'b0)) u3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .mismatch(mis_o[3]), .err(err_o[3]), .err_count(ec3),
    .first_diff(fd_o[3]), .checked(ck3), .halted(halt_o[3]));

  function automatic logic [15:0] ecnt(input int k);
    return (k == 3) ? {14'd0, ec3} : ecnt_w[k];
  endfunction

  function automatic logic [15:0] chk(input int k);
    return (k == 3) ? {14'd0, ck3} : chk_w[k];
  endfunction

  typedef struct {
    int due;
    bit mis;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] c_sched[int];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance one cycle and compare the mismatch pulse of instance k with the
  // scoreboard: a due entry gives the expected pulse, otherwise none.
  task automatic tick(input int k);
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("mismatch", {31'd0, mis_o[k]}, {31'd0, e.mis});
    end else begin
      check("mismatch_quiet", {31'd0, mis_o[k]}, 32'd0);
    end
  endtask

  // Drive one cycle of stimulus. A launched beat schedules c = a^b^mask
  // lat cycles later and, when it is expected to be compared, queues the
  // pulse that must follow one cycle after the compare.
  task automatic drive(input int lat, input bit launch, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] mask, input bit expect_cmp);
    en = launch;
    a  = av;
    b  = bv;
    if (launch) begin
      c_sched[cyc + lat] = av ^ bv ^ mask;
      if (expect_cmp) sb.push_back('{cyc + lat + 1, mask != 8'h00});
    end
    if (c_sched.exists(cyc)) begin
      c = c_sched[cyc];
      c_sched.delete(cyc);
    end else begin
      c = 8'($urandom);
    end
  endtask

  task automatic do_reset(input int k);
    rst = 1'b1; en = 1'b0; clr = 1'b0; a = '0; b = '0; c = '0;
    sb.delete();
    c_sched.delete();
    tick(k);
    tick(k);
    rst = 1'b0;
  endtask

  task automatic idle(input int k, input int lat, input int n);
    for (int i = 0; i < n; i++) begin
      tick(k);
      drive(lat, 1'b0, 8'($urandom), 8'($urandom), 8'h00, 1'b0);
    end
  endtask

  task automatic check_zero(input int k, input string tag);
    check({tag, "_err"},        {31'd0, err_o[k]},  32'd0);
    check({tag, "_err_count"},  {16'd0, ecnt(k)},   32'd0);
    check({tag, "_first_diff"}, {24'd0, fd_o[k]},   32'd0);
    check({tag, "_checked"},    {16'd0, chk(k)},    32'd0);
    check({tag, "_halted"},     {31'd0, halt_o[k]}, 32'd0);
  endtask

  initial begin
    int         launched;
    int         b2;
    logic [7:0] masks [8];

    // Reset state of every instance.
    do_reset(0);
    for (int k = 0; k < 4; k++) begin
      check("rst_mismatch", {31'd0, mis_o[k]}, 32'd0);
      check_zero(k, "rst");
    end

    // 100 random beats with random gaps, all correct, LATENCY=1.
    launched = 0;
    while (launched < 100) begin
      tick(0);
      if ($urandom_range(0, 3) != 0) begin
        drive(1, 1'b1, 8'($urandom), 8'($urandom), 8'h00, 1'b1);
        launched++;
      end else begin
        drive(1, 1'b0, 8'($urandom), 8'($urandom), 8'h00, 1'b0);
      end
    end
    idle(0, 1, 3);
    check("t1_checked",   {16'd0, chk(0)},   32'd100);
    check("t1_err",       {31'd0, err_o[0]}, 32'd0);
    check("t1_err_count", {16'd0, ecnt(0)},  32'd0);
    check("t1_sb_empty",  sb.size(),         32'd0);

    // LATENCY=2, beat 5 expects 0x0F but sees 0xFF.
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (i == 5) drive(2, 1'b1, 8'h0F, 8'h00, 8'hF0, 1'b1);
      else        drive(2, 1'b1, 8'($urandom), 8'($urandom), 8'h00, 1'b1);
    end
    idle(1, 2, 4);
    check("t2_err_count",  {16'd0, ecnt(1)},   32'd1);
    check("t2_first_diff", {24'd0, fd_o[1]},   32'h0000_00F0);
    check("t2_checked",    {16'd0, chk(1)},    32'd10);
    check("t2_err",        {31'd0, err_o[1]},  32'd1);
    idle(1, 2, 3);
    check("t2_err_sticky", {31'd0, err_o[1]},  32'd1);
    check("t2_sb_empty",   sb.size(),          32'd0);

    // STOP_ON_FAIL, LATENCY=3: beat 2 fails, beat 3 would fail but is dropped.
    do_reset(2);
    b2 = -100;
    for (int i = 0; i < 10; i++) begin
      tick(2);
      if (i > 2) check("t3_halted", {31'd0, halt_o[2]}, {31'd0, cyc >= b2 + 4});
      if (i == 2) b2 = cyc;
      drive(3, 1'b1, 8'($urandom), 8'($urandom),
            (i == 2 || i == 3) ? 8'h55 : 8'h00, i <= 2);
    end
    idle(2, 3, 5);
    check("t3_halted_hold", {31'd0, halt_o[2]}, 32'd1);
    check("t3_checked",     {16'd0, chk(2)},    32'd3);
    check("t3_err_count",   {16'd0, ecnt(2)},   32'd1);
    check("t3_first_diff",  {24'd0, fd_o[2]},   32'h0000_0055);
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    tick(2);
    check("t3_clr_unhalt",  {31'd0, halt_o[2]}, 32'd0);
    check("t3_clr_checked", {16'd0, chk(2)},    32'd0);

    // CNT_W=2: five mismatches saturate err_count at 3.
    masks = '{8'h00, 8'h01, 8'h80, 8'h00, 8'h40, 8'h20, 8'h00, 8'h10};
    do_reset(3);
    for (int i = 0; i < 8; i++) begin
      tick(3);
      drive(1, 1'b1, 8'($urandom), 8'($urandom), masks[i], 1'b1);
    end
    idle(3, 1, 3);
    check("t4_err_count",  {16'd0, ecnt(3)}, 32'd3);
    check("t4_checked",    {16'd0, chk(3)},  32'd3);
    check("t4_first_diff", {24'd0, fd_o[3]}, 32'h0000_0001);
    check("t4_sb_empty",   sb.size(),        32'd0);

    // clr coincides with a failing compare: the compare is discarded.
    do_reset(0);
    tick(0);
    drive(1, 1'b1, 8'($urandom), 8'($urandom), 8'h3C, 1'b0);
    tick(0);
    clr = 1'b1;
    drive(1, 1'b0, 8'($urandom), 8'($urandom), 8'h00, 1'b0);
    tick(0);
    clr = 1'b0;
    check("t5_err_after_clr",   {31'd0, err_o[0]}, 32'd0);
    check("t5_count_after_clr", {16'd0, ecnt(0)},  32'd0);
    drive(1, 1'b1, 8'($urandom), 8'($urandom), 8'h00, 1'b1);
    idle(0, 1, 3);
    check("t5_checked",   {16'd0, chk(0)},   32'd1);
    check("t5_err",       {31'd0, err_o[0]}, 32'd0);
    check("t5_err_count", {16'd0, ecnt(0)},  32'd0);

    // rst with two failing beats in flight (LATENCY=2): both are flushed.
    do_reset(1);
    tick(1);
    drive(2, 1'b1, 8'($urandom), 8'($urandom), 8'hAA, 1'b0);
    tick(1);
    drive(2, 1'b1, 8'($urandom), 8'($urandom), 8'h81, 1'b0);
    tick(1);
    rst = 1'b1;
    drive(2, 1'b0, 8'($urandom), 8'($urandom), 8'h00, 1'b0);
    tick(1);
    rst = 1'b0;
    drive(2, 1'b0, 8'($urandom), 8'($urandom), 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      drive(2, 1'b0, 8'($urandom), 8'($urandom), 8'h00, 1'b0);
      check_zero(1, "t6");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
